// File: rtl/sda_kernel_fork_join.sv
// sda_kernel_fork_join: forks one kernel go to the enabled lanes and joins their dones.
// Ports: go/done handshake to the control register, per-lane go/done handshakes, busy, runCycles.
module sda_kernel_fork_join #(
   parameter int NumLanes   = 4,
   parameter int CountWidth = 32
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  goValid,
   output logic                  goHoldoff,
   output logic                  doneValid,
   input  logic                  doneStop,
   input  logic [NumLanes-1:0]   laneEnable,
   output logic [NumLanes-1:0]   laneGoValid,
   input  logic [NumLanes-1:0]   laneGoHoldoff,
   input  logic [NumLanes-1:0]   laneDoneValid,
   output logic [NumLanes-1:0]   laneDoneStop,
   output logic                  busy,
   output logic [CountWidth-1:0] runCycles
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISPATCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [NumLanes-1:0]   active_mask;
   logic [NumLanes-1:0]   go_sent;
   logic [NumLanes-1:0]   done_seen;
   logic [NumLanes-1:0]   go_fire;
   logic [NumLanes-1:0]   done_fire;
   logic [NumLanes-1:0]   sent_n;
   logic [NumLanes-1:0]   seen_n;
   logic [CountWidth-1:0] counter;
   logic                  in_run;
   logic                  go_acc;
   logic                  done_xfer;

   assign in_run    = (state == S_DISPATCH) || (state == S_WAIT);
   assign goHoldoff = (state != S_IDLE);
   assign busy      = (state != S_IDLE);
   assign doneValid = (state == S_DONE);

   assign laneGoValid  = (state == S_DISPATCH) ? (active_mask & ~go_sent) : '0;
   // A lane may only complete between its own go and its first done.
   assign laneDoneStop = in_run ? ~(go_sent & ~done_seen) : '1;

   assign go_acc    = (state == S_IDLE) && goValid;
   assign done_xfer = (state == S_DONE) && !doneStop;
   assign go_fire   = laneGoValid & ~laneGoHoldoff;
   assign done_fire = laneDoneValid & ~laneDoneStop;

   // Join test includes this cycle's transfers so DONE follows the last done by one cycle.
   assign sent_n = go_sent | go_fire;
   assign seen_n = done_seen | done_fire;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (goValid) begin
               state_n = (laneEnable == '0) ? S_DONE : S_DISPATCH;
            end
         end
         S_DISPATCH, S_WAIT: begin
            if (sent_n == active_mask) begin
               state_n = (seen_n == active_mask) ? S_DONE : S_WAIT;
            end
         end
         S_DONE: begin
            if (!doneStop) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         active_mask <= '0;
         go_sent     <= '0;
         done_seen   <= '0;
      end else if (go_acc) begin
         active_mask <= laneEnable;
         go_sent     <= '0;
         done_seen   <= '0;
      end else if (in_run) begin
         go_sent   <= sent_n;
         done_seen <= seen_n;
      end
   end

   // Counter reads 0 in IDLE, so it already equals the elapsed cycles on the done transfer.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         counter   <= '0;
         runCycles <= '0;
      end else if (go_acc) begin
         counter <= CountWidth'(1);
      end else if (done_xfer) begin
         runCycles <= counter;
         counter   <= '0;
      end else if ((state != S_IDLE) && !(&counter)) begin
         counter <= counter + CountWidth'(1);
      end
   end

endmodule

// File: tb/tb_sda_kernel_fork_join.sv
// tb_sda_kernel_fork_join: directed vector table, hand sequences and a random run
// against a behavioural model of the fork/join scheduler.
module tb_sda_kernel_fork_join;

   localparam int NL = 4;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          nreset;
   logic          goValid, goHoldoff, doneValid, doneStop, busy;
   logic [NL-1:0] laneEnable, laneGoValid, laneGoHoldoff;
   logic [NL-1:0] laneDoneValid, laneDoneStop;
   logic [31:0]   runCycles;

   logic          s_go, s_gh, s_dv, s_ds, s_busy;
   logic [NL-1:0] s_en, s_lgv, s_hold, s_ldv, s_lds;
   logic [3:0]    s_run;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sda_kernel_fork_join #(.NumLanes(NL), .CountWidth(32)) u_dut (
      .clk(clk), .nreset(nreset),
      .goValid(goValid), .goHoldoff(goHoldoff),
      .doneValid(doneValid), .doneStop(doneStop),
      .laneEnable(laneEnable), .laneGoValid(laneGoValid),
      .laneGoHoldoff(laneGoHoldoff), .laneDoneValid(laneDoneValid),
      .laneDoneStop(laneDoneStop), .busy(busy), .runCycles(runCycles)
   );

   sda_kernel_fork_join #(.NumLanes(NL), .CountWidth(4)) u_sat (
      .clk(clk), .nreset(nreset),
      .goValid(s_go), .goHoldoff(s_gh),
      .doneValid(s_dv), .doneStop(s_ds),
      .laneEnable(s_en), .laneGoValid(s_lgv),
      .laneGoHoldoff(s_hold), .laneDoneValid(s_ldv),
      .laneDoneStop(s_lds), .busy(s_busy), .runCycles(s_run)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          go;
      logic [NL-1:0] en;
      logic [NL-1:0] hold;
      logic [NL-1:0] ldv;
      logic          ds;
      logic [NL-1:0] e_lgv;
      logic          e_dv;
      logic          e_busy;
      logic [NL-1:0] e_lds;
      logic [31:0]   e_run;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic go, input logic [3:0] en, input logic [3:0] hold,
                      input logic [3:0] ldv, input logic ds, input logic [3:0] lgv,
                      input logic dv, input logic bsy, input logic [3:0] lds,
                      input logic [31:0] run);
      vt.push_back('{go, en, hold, ldv, ds, lgv, dv, bsy, lds, run});
   endtask

   // Behavioural model: run flag, done-phase flag, lane bitmaps, elapsed cycles.
   bit          m_busy, m_done;
   logic [3:0]  m_mask, m_sent, m_seen;
   longint      m_cnt, m_run;

   function automatic logic [3:0] m_lgv();
      return (m_busy && !m_done) ? (m_mask & ~m_sent) : 4'h0;
   endfunction

   function automatic logic [3:0] m_lds();
      return (m_busy && !m_done) ? ~(m_sent & ~m_seen) : 4'hF;
   endfunction

   function automatic longint inc(input longint v);
      return (v >= MAXC) ? MAXC : v + 1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_done = 0;
      m_mask = 0; m_sent = 0; m_seen = 0;
      m_cnt = 0; m_run = 0;
   endtask

   task automatic model_step();
      logic [3:0] vg, vs;
      vg = m_lgv();
      vs = m_lds();
      if (!m_busy) begin
         if (goValid) begin
            m_busy = 1;
            m_mask = laneEnable;
            m_sent = 0;
            m_seen = 0;
            m_cnt  = 1;
            m_done = (laneEnable == 4'h0);
         end
      end else if (m_done) begin
         if (!doneStop) begin
            m_run  = m_cnt;
            m_busy = 0;
            m_done = 0;
            m_cnt  = 0;
         end else begin
            m_cnt = inc(m_cnt);
         end
      end else begin
         for (int i = 0; i < NL; i++) begin
            if (vg[i] && !laneGoHoldoff[i]) m_sent[i] = 1'b1;
            if (laneDoneValid[i] && !vs[i]) m_seen[i] = 1'b1;
         end
         m_cnt = inc(m_cnt);
         if (m_sent == m_mask && m_seen == m_mask) m_done = 1;
      end
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      goValid = 0; doneStop = 0; laneEnable = 0;
      laneGoHoldoff = 0; laneDoneValid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_goHoldoff", goHoldoff, 0);
      chk("rst_doneValid", doneValid, 0);
      chk("rst_laneGoValid", laneGoValid, 0);
      chk("rst_laneDoneStop", laneDoneStop, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_runCycles", runCycles, 0);
      @(negedge clk);
      nreset = 1'b1;
   endtask

   initial begin
      s_go = 0; s_en = 0; s_hold = 0; s_ldv = 0; s_ds = 0;

      // go, en, hold, ldv, ds | lgv, dv, busy, lds, run
      add(1, 4'hF, 0, 0,    0, 4'hF, 0, 1, 4'hF, 0);
      add(0, 4'hF, 0, 0,    0, 4'h0, 0, 1, 4'h0, 0);
      add(0, 4'hF, 0, 0,    0, 4'h0, 0, 1, 4'h0, 0);
      add(0, 4'hF, 0, 0,    0, 4'h0, 0, 1, 4'h0, 0);
      add(0, 4'hF, 0, 4'hF, 0, 4'h0, 1, 1, 4'hF, 0);
      add(0, 4'hF, 0, 0,    0, 4'h0, 0, 0, 4'hF, 5);
      add(1, 4'h1, 0, 4'h2, 0, 4'h1, 0, 1, 4'hF, 5);
      add(1, 4'h1, 0, 4'h2, 0, 4'h0, 0, 1, 4'hE, 5);
      add(1, 4'h1, 0, 4'h2, 0, 4'h0, 0, 1, 4'hE, 5);
      add(1, 4'h1, 0, 4'h2, 0, 4'h0, 0, 1, 4'hE, 5);
      add(1, 4'h1, 0, 4'h3, 0, 4'h0, 1, 1, 4'hF, 5);
      add(1, 4'h1, 0, 0,    0, 4'h0, 0, 0, 4'hF, 5);
      add(1, 4'h0, 0, 0,    1, 4'h0, 1, 1, 4'hF, 5);
      add(0, 4'h0, 0, 0,    1, 4'h0, 1, 1, 4'hF, 5);
      add(0, 4'h0, 0, 0,    1, 4'h0, 1, 1, 4'hF, 5);
      add(0, 4'h0, 0, 0,    1, 4'h0, 1, 1, 4'hF, 5);
      add(0, 4'h0, 0, 0,    0, 4'h0, 0, 0, 4'hF, 4);
      add(1, 4'h5, 0,    0,    0, 4'h5, 0, 1, 4'hF, 4);
      add(0, 4'h5, 4'h4, 0,    0, 4'h4, 0, 1, 4'hE, 4);
      add(0, 4'h5, 4'h4, 4'h1, 0, 4'h4, 0, 1, 4'hF, 4);
      add(0, 4'h5, 4'h4, 0,    0, 4'h4, 0, 1, 4'hF, 4);
      add(0, 4'h5, 4'h4, 0,    0, 4'h4, 0, 1, 4'hF, 4);
      add(0, 4'h5, 4'h4, 0,    0, 4'h4, 0, 1, 4'hF, 4);
      add(0, 4'h5, 4'h4, 0,    0, 4'h4, 0, 1, 4'hF, 4);
      add(0, 4'h5, 0,    0,    0, 4'h0, 0, 1, 4'hB, 4);
      add(0, 4'h5, 0,    4'h5, 0, 4'h0, 1, 1, 4'hF, 4);
      add(0, 4'h5, 0,    0,    0, 4'h0, 0, 0, 4'hF, 9);

      do_reset();

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         goValid       = vt[i].go;
         laneEnable    = vt[i].en;
         laneGoHoldoff = vt[i].hold;
         laneDoneValid = vt[i].ldv;
         doneStop      = vt[i].ds;
         @(posedge clk);
         #1;
         chk($sformatf("r%0d_lgv", i), laneGoValid, vt[i].e_lgv);
         chk($sformatf("r%0d_dv", i), doneValid, vt[i].e_dv);
         chk($sformatf("r%0d_busy", i), busy, vt[i].e_busy);
         chk($sformatf("r%0d_gh", i), goHoldoff, vt[i].e_busy);
         chk($sformatf("r%0d_lds", i), laneDoneStop, vt[i].e_lds);
         chk($sformatf("r%0d_run", i), runCycles, vt[i].e_run);
      end

      // Reset in the middle of WAIT, with goValid held high across release.
      @(negedge clk);
      goValid = 1; laneEnable = 4'hF; laneGoHoldoff = 0;
      laneDoneValid = 0; doneStop = 0;
      @(posedge clk);
      #1 chk("s6_dispatch_lgv", laneGoValid, 4'hF);
      @(posedge clk);
      #1 chk("s6_wait_lds", laneDoneStop, 4'h0);
      chk("s6_wait_busy", busy, 1);
      #2 nreset = 1'b0;
      laneDoneValid = 4'hF;
      #1;
      chk("s6_rst_lgv", laneGoValid, 0);
      chk("s6_rst_dv", doneValid, 0);
      chk("s6_rst_gh", goHoldoff, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_lds", laneDoneStop, 4'hF);
      chk("s6_rst_run", runCycles, 0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk("s6_reacc_busy", busy, 1);
      chk("s6_reacc_lgv", laneGoValid, 4'hF);
      chk("s6_reacc_dv", doneValid, 0);
      chk("s6_reacc_lds", laneDoneStop, 4'hF);
      @(negedge clk);
      goValid = 0; laneDoneValid = 0;

      // Saturating counter on the 4-bit instance: a run far longer than 15 cycles.
      @(negedge clk);
      s_go = 1; s_en = 4'h1;
      @(negedge clk);
      s_go = 0;
      repeat (20) @(negedge clk);
      s_ldv = 4'h1;
      @(posedge clk);
      #1 chk("s5_dv", s_dv, 1);
      chk("s5_run_before", s_run, 0);
      @(negedge clk);
      s_ldv = 0;
      @(posedge clk);
      #1 chk("s5_run_sat", s_run, 4'hF);
      chk("s5_busy", s_busy, 0);

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         goValid       = ($urandom_range(0, 9) < 4);
         laneEnable    = 4'($urandom_range(0, 15));
         doneStop      = ($urandom_range(0, 9) < 4);
         for (int i = 0; i < NL; i++) begin
            laneGoHoldoff[i] = ($urandom_range(0, 9) < 3);
            laneDoneValid[i] = ($urandom_range(0, 9) < 4);
         end
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_lgv", laneGoValid, m_lgv());
         chk("rnd_lds", laneDoneStop, m_lds());
         chk("rnd_dv", doneValid, m_done);
         chk("rnd_gh", goHoldoff, m_busy);
         chk("rnd_busy", busy, m_busy);
         chk("rnd_run", runCycles, m_run);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
